// File: rtl/i2si_bist_pattern_gen.sv
// BIST stereo sample generator: one sample per frame of FRAME_BITS sck_transition pulses.
// Waveforms: sawtooth, triangle, square, constant. Data word = {~S, S}, registered.
// xfc is a combinational 1-clk strobe on each RUN frame boundary, gated by enable.
module i2si_bist_pattern_gen #(
  parameter int DATA_W     = 16,
  parameter int CFG_W      = 12,
  parameter int INC_W      = 8,
  parameter int FRAME_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sck_transition,
  input  logic                rf_bist_en,
  input  logic [1:0]          rf_bist_mode,
  input  logic [CFG_W-1:0]    rf_bist_start_val,
  input  logic [CFG_W-1:0]    rf_bist_up_limit,
  input  logic [INC_W-1:0]    rf_bist_inc,
  output logic [2*DATA_W-1:0] i2si_bist_out_data,
  output logic                i2si_bist_out_xfc,
  output logic                i2si_bist_active
);

  localparam int              CNT_W   = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS - 1);

  localparam logic [1:0] MODE_SAW   = 2'd0;
  localparam logic [1:0] MODE_TRI   = 2'd1;
  localparam logic [1:0] MODE_SQR   = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_t;

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_frame_cnt;
  logic signed [DATA_W-1:0]  r_s, w_s_nxt;
  logic                      r_dir_down, w_dir_down_nxt;
  logic [DATA_W-1:0]         r_sq_cnt, w_sq_cnt_nxt;
  logic                      r_sq_phase, w_sq_phase_nxt;
  logic [1:0]                r_mode_q, w_mode_q_nxt;

  logic                      w_boundary;
  logic signed [DATA_W-1:0]  w_start, w_limit;
  logic [DATA_W-1:0]         w_inc, w_sq_period, w_sq_cnt_inc;
  logic signed [DATA_W:0]    w_s_ext, w_start_ext, w_limit_ext, w_inc_ext, w_sum, w_diff;
  logic                      w_degenerate;

  // Config extension and wide next-value arithmetic (one guard bit, so no silent wrap)
  assign w_start      = DATA_W'($signed(rf_bist_start_val));
  assign w_limit      = DATA_W'($signed(rf_bist_up_limit));
  assign w_inc        = DATA_W'(rf_bist_inc);
  assign w_s_ext      = (DATA_W+1)'(r_s);
  assign w_start_ext  = (DATA_W+1)'(w_start);
  assign w_limit_ext  = (DATA_W+1)'(w_limit);
  assign w_inc_ext    = $signed({1'b0, w_inc});
  assign w_sum        = w_s_ext + w_inc_ext;
  assign w_diff       = w_s_ext - w_inc_ext;
  assign w_degenerate = (w_limit_ext <= w_start_ext) || (w_inc == '0);
  assign w_sq_period  = (w_inc == '0) ? DATA_W'(1) : w_inc;
  assign w_sq_cnt_inc = r_sq_cnt + DATA_W'(1);

  assign w_boundary         = sck_transition && (r_frame_cnt == CNT_MAX);
  assign i2si_bist_out_xfc  = w_boundary && rf_bist_en && (r_state == ST_RUN);
  assign i2si_bist_out_data = {~r_s, r_s};
  assign i2si_bist_active   = (r_state == ST_RUN);

  // Frame position counter, free-running on serial-clock edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_frame_cnt <= CNT_MAX;
    else if (sck_transition) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
  end

  // Next-state and waveform step; config is only looked at on a frame boundary
  always_comb begin
    w_state_nxt    = r_state;
    w_s_nxt        = r_s;
    w_dir_down_nxt = r_dir_down;
    w_sq_cnt_nxt   = r_sq_cnt;
    w_sq_phase_nxt = r_sq_phase;
    w_mode_q_nxt   = r_mode_q;
    case (r_state)
      ST_IDLE: begin
        if (rf_bist_en) w_state_nxt = ST_ARM;
      end
      ST_ARM, ST_RUN: begin
        if (!rf_bist_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_boundary) begin
          w_state_nxt = ST_RUN;
          if (r_state == ST_ARM || rf_bist_mode != r_mode_q) begin
            w_s_nxt        = w_start;
            w_dir_down_nxt = 1'b0;
            w_sq_cnt_nxt   = '0;
            w_sq_phase_nxt = 1'b0;
            w_mode_q_nxt   = rf_bist_mode;
          end else begin
            case (r_mode_q)
              MODE_SAW: begin
                w_s_nxt = (w_s_ext >= w_limit_ext) ? w_start : w_sum[DATA_W-1:0];
              end
              MODE_TRI: begin
                if (w_degenerate) begin
                  w_s_nxt        = w_start;
                  w_dir_down_nxt = 1'b0;
                end else if (!r_dir_down) begin
                  if (w_sum >= w_limit_ext) begin
                    w_s_nxt        = w_limit;
                    w_dir_down_nxt = 1'b1;
                  end else begin
                    w_s_nxt = w_sum[DATA_W-1:0];
                  end
                end else begin
                  if (w_diff <= w_start_ext) begin
                    w_s_nxt        = w_start;
                    w_dir_down_nxt = 1'b0;
                  end else begin
                    w_s_nxt = w_diff[DATA_W-1:0];
                  end
                end
              end
              MODE_SQR: begin
                if (w_sq_cnt_inc >= w_sq_period) begin
                  w_sq_cnt_nxt   = '0;
                  w_sq_phase_nxt = ~r_sq_phase;
                end else begin
                  w_sq_cnt_nxt = w_sq_cnt_inc;
                end
                w_s_nxt = w_sq_phase_nxt ? w_limit : w_start;
              end
              MODE_CONST: w_s_nxt = w_start;
              default:    w_s_nxt = w_start;
            endcase
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and waveform registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_s        <= '0;
      r_dir_down <= 1'b0;
      r_sq_cnt   <= '0;
      r_sq_phase <= 1'b0;
      r_mode_q   <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_s        <= w_s_nxt;
      r_dir_down <= w_dir_down_nxt;
      r_sq_cnt   <= w_sq_cnt_nxt;
      r_sq_phase <= w_sq_phase_nxt;
      r_mode_q   <= w_mode_q_nxt;
    end
  end

endmodule

// File: tb/tb_i2si_bist_pattern_gen.sv
// Directed bench for the BIST pattern generator with an expected-sample queue.
// Expected samples are pushed before frames run and popped on each xfc strobe.
// Pulses carry random idle gaps; frame position is tracked by a bench counter.
module tb_i2si_bist_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck;
  logic        en;
  logic [1:0]  mode;
  logic [11:0] start_val;
  logic [11:0] up_limit;
  logic [7:0]  inc;
  logic [31:0] dout;
  logic        xfc;
  logic        active;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          tb_cnt  = 31;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  i2si_bist_pattern_gen #(
    .DATA_W(16), .CFG_W(12), .INC_W(8), .FRAME_BITS(32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .sck_transition    (sck),
    .rf_bist_en        (en),
    .rf_bist_mode      (mode),
    .rf_bist_start_val (start_val),
    .rf_bist_up_limit  (up_limit),
    .rf_bist_inc       (inc),
    .i2si_bist_out_data(dout),
    .i2si_bist_out_xfc (xfc),
    .i2si_bist_active  (active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One sck_transition pulse; checks xfc while high and the popped sample after the edge
  task automatic pulse(input bit exp_xfc);
    logic [15:0] e;
    @(posedge clk); #1 sck = 1'b1;
    #3 chk("xfc", 32'(xfc), 32'(exp_xfc));
    @(posedge clk); #1 sck = 1'b0;
    if (exp_xfc) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL scoreboard: observed empty queue expected a sample");
      end else begin
        e = sb.pop_front();
        chk("data", dout, {~e, e});
      end
      #1 chk("xfc_width", 32'(xfc), 32'd0);
    end
    tb_cnt = (tb_cnt + 1) % 32;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_to_boundary(input bit exp_xfc);
    while (tb_cnt != 31) pulse(1'b0);
    pulse(exp_xfc);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) run_to_boundary(1'b1);
  endtask

  // Disable, load config, re-enable and take the ARM boundary (no xfc there)
  task automatic arm(input logic [1:0] m, input logic [11:0] s, input logic [11:0] l,
                     input logic [7:0] i, input logic [15:0] exp_start);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mode = m; start_val = s; up_limit = l; inc = i; en = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("active_arm", 32'(active), 32'd0);
    run_to_boundary(1'b0);
    chk("arm_data", dout, {~exp_start, exp_start});
    chk("active_run", 32'(active), 32'd1);
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; en = 1'b0; mode = 2'd0;
    start_val = '0; up_limit = '0; inc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",   dout,           32'hFFFF_0000);
    chk("rst_xfc",    32'(xfc),       32'd0);
    chk("rst_active", 32'(active),    32'd0);
    rst = 1'b0;

    // Sawtooth: 0x10 step 4 up to 0x1C then wrap to start
    arm(2'd0, 12'h010, 12'h01C, 8'd4, 16'h0010);
    sb.push_back(16'h0014); sb.push_back(16'h0018);
    sb.push_back(16'h001C); sb.push_back(16'h0010);
    run_frames(4);

    // Mode switch mid-frame reloads START on the next boundary, then stays constant
    sb.push_back(16'h0014); sb.push_back(16'h0018);
    run_frames(2);
    repeat (5) pulse(1'b0);
    mode = 2'd3;
    sb.push_back(16'h0010); sb.push_back(16'h0010);
    run_frames(2);

    // Enable low: no xfc, data held
    en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("active_off", 32'(active), 32'd0);
    run_to_boundary(1'b0);
    chk("held_data", dout, {~16'h0010, 16'h0010});

    // Triangle with exact limit hit
    arm(2'd1, 12'hFFE, 12'h004, 8'd3, 16'hFFFE);
    sb.push_back(16'h0001); sb.push_back(16'h0004); sb.push_back(16'h0001);
    sb.push_back(16'hFFFE); sb.push_back(16'h0001);
    run_frames(5);

    // Triangle with clamp at limit
    arm(2'd1, 12'hFFE, 12'h005, 8'd3, 16'hFFFE);
    sb.push_back(16'h0001); sb.push_back(16'h0004); sb.push_back(16'h0005);
    sb.push_back(16'h0002); sb.push_back(16'hFFFF); sb.push_back(16'hFFFE);
    run_frames(6);

    // Square, half-period 2 frames
    arm(2'd2, 12'h005, 12'h009, 8'd2, 16'h0005);
    sb.push_back(16'h0005); sb.push_back(16'h0009); sb.push_back(16'h0009);
    sb.push_back(16'h0005); sb.push_back(16'h0005);
    run_frames(5);

    // Square with inc=0 toggles every frame
    arm(2'd2, 12'h005, 12'h009, 8'd0, 16'h0005);
    sb.push_back(16'h0009); sb.push_back(16'h0005); sb.push_back(16'h0009);
    run_frames(3);

    // Degenerate limit below start: triangle holds START
    arm(2'd1, 12'h005, 12'h003, 8'd2, 16'h0005);
    sb.push_back(16'h0005); sb.push_back(16'h0005);
    run_frames(2);

    // Reset in the middle of a frame
    repeat (10) pulse(1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_data",   dout,        32'hFFFF_0000);
    chk("midrst_xfc",    32'(xfc),    32'd0);
    chk("midrst_active", 32'(active), 32'd0);
    #5 rst = 1'b0;
    tb_cnt = 31;
    @(posedge clk); #1;
    chk("post_rst_active", 32'(active), 32'd0);
    run_to_boundary(1'b0);
    chk("post_rst_start", dout, {~16'h0005, 16'h0005});
    sb.push_back(16'h0005);
    run_frames(1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
